// File: rtl/seq_mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier:
// FSM state encoding and the operand-width legality check.
package seq_mul_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_FIX   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        FIX   = ST_FIX,
        DONE  = ST_DONE
    } state_t;

    localparam int MIN_WIDTH = 4;
    localparam int MAX_WIDTH = 32;

    function automatic bit width_ok(input int w);
        return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
    endfunction

endpackage

// File: rtl/seq_mul_param_dp.sv
// Multiplier datapath: magnitude capture, shift-add core,
// final sign fix-up and the held result register.
module seq_mul_param_dp
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic               fix,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] result
);

    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   p_q;
    logic               neg_q;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;

    // Operand magnitudes, partial-sum adder and the unsigned product
    always_comb begin
        a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
        b_mag = (is_signed && b[WIDTH-1]) ? -b : b;
        sum   = {1'b0, p_q} + {1'b0, {WIDTH{a_q[0]}} & b_q};
        prod  = {p_q, a_q};
    end

    // Operand capture, one shift-add step per cycle, result write in FIX
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            p_q    <= '0;
            neg_q  <= 1'b0;
            result <= '0;
        end else begin
            if (load) begin
                a_q   <= a_mag;
                b_q   <= b_mag;
                p_q   <= '0;
                neg_q <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            end else if (step) begin
                p_q <= sum[WIDTH:1];
                a_q <= {sum[0], a_q[WIDTH-1:1]};
            end
            if (fix) begin
                result <= neg_q ? -prod : prod;
            end
        end
    end

endmodule

// File: rtl/seq_mul_param.sv
// Parametrised sequential multiplier: FSM, step counter and
// ready/start/done handshake around the shift-add datapath.
module seq_mul_param
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);

    // Refuse to elaborate with an unsupported operand width
    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("seq_mul_param: WIDTH must be in 4..32");
    end

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] count;
    logic             load;
    logic             step;
    logic             fix;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Shift-step counter, cleared on accept
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (step) begin
            count <= count + 1'b1;
        end
    end

    // Next-state and datapath strobes
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        fix      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (count == CNT_W'(WIDTH - 1)) begin
                    state_nx = FIX;
                end
            end
            FIX: begin
                fix      = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign ready = (state == IDLE);
    assign busy  = (state == SHIFT) || (state == FIX);
    assign done  = (state == DONE);

    seq_mul_param_dp #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (step),
        .fix      (fix),
        .is_signed(is_signed),
        .a        (a),
        .b        (b),
        .result   (result)
    );

endmodule

// File: tb/tb_seq_mul_param.sv
// Self-checking bench for seq_mul_param at WIDTH 4, 8, 24
// (default) and 32, with a scoreboard of reference products.
module tb_seq_mul_param;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        st [4];
    logic        sg [4];
    logic        rdy[4];
    logic        bsy[4];
    logic        dn [4];
    logic [3:0]  a4, b4;
    logic [7:0]  a8, b8;
    logic [23:0] a24, b24;
    logic [31:0] a32, b32;
    logic [7:0]  r4;
    logic [15:0] r8;
    logic [47:0] r24;
    logic [63:0] r32;

    seq_mul_param #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst(rst), .start(st[0]), .is_signed(sg[0]),
        .a(a4), .b(b4), .ready(rdy[0]), .busy(bsy[0]),
        .done(dn[0]), .result(r4));

    seq_mul_param #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .start(st[1]), .is_signed(sg[1]),
        .a(a8), .b(b8), .ready(rdy[1]), .busy(bsy[1]),
        .done(dn[1]), .result(r8));

    seq_mul_param u_w24 (
        .clk(clk), .rst(rst), .start(st[2]), .is_signed(sg[2]),
        .a(a24), .b(b24), .ready(rdy[2]), .busy(bsy[2]),
        .done(dn[2]), .result(r24));

    seq_mul_param #(.WIDTH(32)) u_w32 (
        .clk(clk), .rst(rst), .start(st[3]), .is_signed(sg[3]),
        .a(a32), .b(b32), .ready(rdy[3]), .busy(bsy[3]),
        .done(dn[3]), .result(r32));

    typedef struct {
        int          idx;
        logic [63:0] val;
    } exp_t;

    typedef struct {
        int          idx;
        bit          s;
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] exp;
    } vec_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic int wd(input int i);
        case (i)
            0:       return 4;
            1:       return 8;
            2:       return 24;
            default: return 32;
        endcase
    endfunction

    function automatic logic [63:0] res(input int i);
        case (i)
            0:       return {56'b0, r4};
            1:       return {48'b0, r8};
            2:       return {16'b0, r24};
            default: return r32;
        endcase
    endfunction

    function automatic logic [63:0] mask(input int n);
        if (n >= 64) return '1;
        return (64'd1 << n) - 64'd1;
    endfunction

    function automatic logic [63:0] sext(input logic [63:0] v, input int w);
        logic signed [63:0] t;
        t = v << (64 - w);
        return t >>> (64 - w);
    endfunction

    // Reference: full 64-bit multiply of (sign-)extended operands
    function automatic logic [63:0] ref_mul(input int w, input bit s,
                                            input logic [31:0] x,
                                            input logic [31:0] y);
        logic [63:0] xe, ye;
        xe = {32'b0, x} & mask(w);
        ye = {32'b0, y} & mask(w);
        if (s) begin
            xe = sext(xe, w);
            ye = sext(ye, w);
        end
        return (xe * ye) & mask(2 * w);
    endfunction

    task automatic set_ops(input int i, input logic [31:0] x,
                           input logic [31:0] y);
        case (i)
            0: begin a4 = x[3:0]; b4 = y[3:0]; end
            1: begin a8 = x[7:0]; b8 = y[7:0]; end
            2: begin a24 = x[23:0]; b24 = y[23:0]; end
            default: begin a32 = x; b32 = y; end
        endcase
    endtask

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One operation on DUT i; entered and left #1 after a rising edge.
    // Inputs and stray starts are scrambled while the DUT is busy.
    task automatic run_op(input int i, input bit s, input logic [31:0] x,
                          input logic [31:0] y, output int lat);
        int          k;
        bit          seen;
        bit          stable;
        logic [63:0] held;
        exp_t        e;
        k = 0;
        while (!rdy[i] && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("ready_wait", 64'(rdy[i]), 64'd1);
        sg[i] = s;
        set_ops(i, x, y);
        st[i] = 1'b1;
        sb.push_back('{i, ref_mul(wd(i), s, x, y)});
        held = res(i);
        @(posedge clk); #1;
        lat    = 0;
        seen   = 1'b0;
        stable = 1'b1;
        while (!seen && lat < wd(i) + 10) begin
            st[i] = 1'($urandom);
            sg[i] = 1'($urandom);
            set_ops(i, $urandom, $urandom);
            @(posedge clk); #1;
            lat++;
            if (dn[i]) seen = 1'b1;
            else if (res(i) !== held) stable = 1'b0;
        end
        st[i] = 1'b0;
        check("done_timeout", 64'(seen), 64'd1);
        check("result_stable", 64'(stable), 64'd1);
        if (sb.size() == 0) begin
            check("sb_empty", 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            check("sb_result", res(e.idx), e.val);
        end
        @(posedge clk); #1;
        check("ready_back", {62'b0, rdy[i], dn[i]}, 64'd2);
    endtask

    vec_t tbl[11];

    initial begin
        int lat;
        int cyc;
        int t1;
        int t2;
        logic [31:0] x;
        logic [31:0] y;

        tbl[0]  = '{1, 1'b0, 32'hFF,       32'hFF,       64'hFE01};
        tbl[1]  = '{1, 1'b1, 32'h80,       32'h80,       64'h4000};
        tbl[2]  = '{1, 1'b1, 32'hFF,       32'h01,       64'hFFFF};
        tbl[3]  = '{1, 1'b1, 32'h00,       32'hFB,       64'h0000};
        tbl[4]  = '{1, 1'b1, 32'h7F,       32'h80,       64'hC080};
        tbl[5]  = '{2, 1'b0, 32'hFFFFFF,   32'h800000,   64'h7FFFFF800000};
        tbl[6]  = '{2, 1'b1, 32'hFFFFFF,   32'hFFFFFF,   64'h1};
        tbl[7]  = '{0, 1'b1, 32'h8,        32'h8,        64'h40};
        tbl[8]  = '{0, 1'b0, 32'hF,        32'hF,        64'hE1};
        tbl[9]  = '{3, 1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000};
        tbl[10] = '{3, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};

        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            st[i] = 1'b0;
            sg[i] = 1'b0;
            set_ops(i, 32'h0, 32'h0);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            check("rst_flags", {61'b0, rdy[i], bsy[i], dn[i]}, 64'd4);
            check("rst_result", res(i), 64'd0);
        end
        rst = 1'b0;

        for (int v = 0; v < 11; v++) begin
            run_op(tbl[v].idx, tbl[v].s, tbl[v].x, tbl[v].y, lat);
            check("vec_latency", 64'(lat), 64'(wd(tbl[v].idx) + 1));
            check("vec_result", res(tbl[v].idx), tbl[v].exp);
        end

        // start held high: back-to-back products every WIDTH+3 cycles
        sg[1] = 1'b0;
        a8    = 8'd13;
        b8    = 8'd11;
        st[1] = 1'b1;
        cyc   = 0;
        t1    = -1;
        t2    = -1;
        while (t2 < 0 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (dn[1]) begin
                if (t1 < 0) t1 = cyc;
                else t2 = cyc;
            end
        end
        st[1] = 1'b0;
        check("held_first_done", 64'(t1), 64'd10);
        check("held_period", 64'(t2 - t1), 64'd11);
        check("held_result", res(1), 64'h8F);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("held_not_queued", {62'b0, rdy[1], bsy[1]}, 64'd2);

        // reset during the third shift step
        a8    = 8'd200;
        b8    = 8'd3;
        st[1] = 1'b1;
        @(posedge clk); #1;
        st[1] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_flags", {61'b0, rdy[1], bsy[1], dn[1]}, 64'd4);
        check("midrst_result", res(1), 64'd0);
        run_op(1, 1'b0, 32'd200, 32'd3, lat);
        check("midrst_after", res(1), 64'h258);
        check("midrst_latency", 64'(lat), 64'd9);

        // reset and start on the same edge: start is dropped
        rst   = 1'b1;
        st[1] = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        st[1] = 1'b0;
        check("rst_start_flags", {61'b0, rdy[1], bsy[1], dn[1]}, 64'd4);
        @(posedge clk); #1;
        check("rst_start_idle", {62'b0, rdy[1], bsy[1]}, 64'd2);
        check("rst_start_result", res(1), 64'd0);

        // random regression with corner operands mixed in
        for (int i = 0; i < 4; i++) begin
            for (int s = 0; s < 2; s++) begin
                for (int n = 0; n < 150; n++) begin
                    x = $urandom;
                    y = $urandom;
                    if (n % 16 == 0) x = 32'd1 << (wd(i) - 1);
                    if (n % 16 == 1) y = 32'd0;
                    if (n % 16 == 2) x = '1;
                    run_op(i, s[0], x, y, lat);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
